decoder_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 3-to-8 decoder among 8 requesters.
//  - Selects one requester, then drives the decoder's enable and 3-bit select.
//  - The decoder's 8-bit one-hot output is the grant vector.
//  - Sits between requesting units and the shared resource; one owner at a time.

---
 rtl/decoder_rr_arbiter_pkg.sv | 22 ++
 rtl/decoder_rr_arbiter_decoder_38.sv | 23 ++
 rtl/decoder_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter around a 3-to-8 decoder.
//  - state_e : two-state arbiter FSM encoding (IDLE / BUSY)
//  - NREQ    : number of requesters
//  - IDX_W   : width of a requester index / decoder select
//  - pick_t  : result of the rotating priority search
package decoder_rr_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Priority-search result: hit is set when any request was present.
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } pick_t;

endpackage : decoder_rr_arbiter_pkg

// File: rtl/decoder_rr_arbiter_decoder_38.sv
// 3-to-8 one-hot decoder with enable; purely combinational.
// Ports:
//   en   in  1      decoder enable; all outputs low when 0
//   in   in  IDX_W  binary select
//   out  out NREQ   one-hot output, bit 'in' set when enabled
module decoder_38
  import decoder_rr_arbiter_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] in,
  output logic [NREQ-1:0]  out
);

  // Driven only from registered en/in upstream, so the output cannot glitch
  // on the arbiter's request/release inputs.
  always_comb begin
    out = '0;
    if (en) begin
      out[in] = 1'b1;
    end
  end

endmodule : decoder_38

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters.
// The winner's index drives the decoder select, the held-grant flag drives
// the decoder enable, and the decoder output is the one-hot grant vector.
// Optional feature: define GRANT_TIMEOUT_EN to force-release a grant that
// has been held for HOLD_MAX cycles (timeout pulses on that release).
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   req        in   8  level requests, bit i = requester i
//   rel        in   1  release pulse from the current owner
//   gnt        out  8  one-hot grant (decoder output)
//   gnt_valid  out  1  grant held (decoder enable), registered
//   gnt_idx    out  3  current owner index (decoder select), registered
//   timeout    out  1  one-cycle pulse on a forced release, registered
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             rel,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  // Elaboration guard: the hold counter must be able to reach HOLD_MAX-1.
  if ((2 ** CNT_W) <= HOLD_MAX) begin : g_cnt_w_check
    $error("decoder_rr_arbiter: CNT_W too narrow for HOLD_MAX");
  end

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] gnt_idx_d;
  logic             gnt_valid_d;
  pick_t            pick;
  logic             release_c;
  logic             expire;

`ifdef GRANT_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_d;
`endif

  // Rotate requests so bit ptr lands at position 0, then take the lowest
  // set bit; adding ptr back gives the absolute index (3-bit wrap).
  function automatic pick_t rr_pick(input logic [NREQ-1:0]  r,
                                    input logic [IDX_W-1:0] p);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    pick_t             res;
    dbl     = {r, r} >> p;
    rot     = dbl[NREQ-1:0];
    res.hit = |r;
    res.idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        res.idx = p + IDX_W'(i);
      end
    end
    return res;
  endfunction

  assign pick = rr_pick(req, ptr_q);

  // An explicit release and the owner dropping its request merge into one.
  assign release_c = rel | ~req[gnt_idx];

`ifdef GRANT_TIMEOUT_EN
  assign expire = (cnt_q == CNT_W'(HOLD_MAX - 1));
`else
  assign expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick.hit) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_c || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and hold counter.
  always_comb begin
    gnt_idx_d   = gnt_idx;
    ptr_d       = ptr_q;
    gnt_valid_d = (state_d == BUSY);
`ifdef GRANT_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick.hit) begin
          gnt_idx_d = pick.idx;
`ifdef GRANT_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      BUSY: begin
        if (release_c || expire) begin
          // Owner moves to the back of the rotation.
          ptr_d = gnt_idx + IDX_W'(1);
`ifdef GRANT_TIMEOUT_EN
          timeout_d = ~release_c;
`endif
        end else begin
`ifdef GRANT_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        gnt_idx_d = gnt_idx;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Hold counter and forced-release pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Shared decoder: enable = held grant, select = owner index.
  decoder_38 u_decoder_38 (
    .en  (gnt_valid),
    .in  (gnt_idx),
    .out (gnt)
  );

endmodule : decoder_rr_arbiter

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter: a cycle-level reference model
// pushes the expected outputs after every clock edge; a monitor on the
// falling edge pops and compares them with the DUT.
module tb_decoder_rr_arbiter;

  localparam int HOLD_MAX = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  // Reference model state: who owns the resource and for how long.
  typedef struct {
    bit busy;
    int owner;
    int ptr;
    int held;
    bit to;
  } mdl_t;

  typedef struct {
    logic [7:0] gnt;
    logic       v;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  mdl_t m = '{busy: 1'b0, owner: 0, ptr: 0, held: 0, to: 1'b0};
  exp_t expq[$];

  function automatic mdl_t next_model(mdl_t cur, logic [7:0] r, logic l, logic rn);
    mdl_t n;
    n    = cur;
    n.to = 1'b0;
    if (!rn) begin
      n.busy = 1'b0; n.owner = 0; n.ptr = 0; n.held = 0;
    end else if (!cur.busy) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (cur.ptr + k) % 8;
        if (r[c]) begin
          n.busy = 1'b1; n.owner = c; n.held = 0;
          break;
        end
      end
    end else begin
      bit gone;
      bit expired;
      gone    = l || !r[cur.owner];
      expired = 1'b0;
`ifdef GRANT_TIMEOUT_EN
      // This edge closes BUSY cycle number held+1.
      expired = ((cur.held + 1) == HOLD_MAX);
`endif
      if (gone || expired) begin
        n.busy = 1'b0;
        n.ptr  = (cur.owner + 1) % 8;
        n.to   = !gone && expired;
      end else begin
        n.held = cur.held + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t view(mdl_t s);
    exp_t e;
    e.gnt = s.busy ? (8'd1 << s.owner) : 8'd0;
    e.v   = s.busy;
    e.idx = 3'(s.owner);
    e.to  = s.to;
    return e;
  endfunction

  // Model advances on every edge with the inputs the DUT sampled.
  always @(posedge clk) begin
    expq.push_back(view(next_model(m, req, rel, rst_n)));
    m     <= next_model(m, req, rel, rst_n);
    edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per edge, compared mid-cycle.
  always @(negedge clk) begin
    if (edges > 0) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty got 0 expected 1 at %0t", $time);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("gnt",       32'(gnt),       32'(e.gnt));
        chk("gnt_valid", 32'(gnt_valid), 32'(e.v));
        chk("gnt_idx",   32'(gnt_idx),   32'(e.idx));
        chk("timeout",   32'(timeout),   32'(e.to));
      end
    end
  end

  task automatic cyc(input logic [7:0] r, input logic l, input int n);
    req = r;
    rel = l;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    rel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester, grant then release.
    cyc(8'h08, 1'b0, 3);
    cyc(8'h08, 1'b1, 1);
    cyc(8'h00, 1'b0, 2);

    // All requesting, periodic releases: full rotation with wrap.
    for (int i = 0; i < 48; i++) cyc(8'hFF, (i % 3) == 2, 1);
    cyc(8'h00, 1'b0, 2);

    // Fairness: owner 5 released, then 0 wins, then 5 again.
    cyc(8'h20, 1'b0, 2);
    cyc(8'h21, 1'b1, 1);
    cyc(8'h21, 1'b0, 3);
    cyc(8'h21, 1'b1, 1);
    cyc(8'h21, 1'b0, 3);
    cyc(8'h00, 1'b0, 2);

    // Owner drops its request; another requester follows after IDLE.
    cyc(8'h04, 1'b0, 2);
    cyc(8'h40, 1'b0, 3);
    cyc(8'h00, 1'b0, 2);

    // rel while idle is ignored; rel and drop together.
    cyc(8'h00, 1'b1, 2);
    cyc(8'h02, 1'b0, 2);
    cyc(8'h00, 1'b1, 2);

    // Long hold without release (forced release when the timeout is built).
    cyc(8'h01, 1'b0, 120);
    cyc(8'h00, 1'b0, 2);

    // Reset while busy: grant drops, pointer returns to 0.
    cyc(8'h10, 1'b0, 2);
    rst_n = 1'b0;
    cyc(8'h10, 1'b0, 1);
    rst_n = 1'b1;
    cyc(8'hFF, 1'b0, 2);
    cyc(8'h00, 1'b0, 2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(8'($urandom & $urandom), ($urandom_range(0, 3) == 0), 1);
    end
    rst_n = 1'b1;
    cyc(8'h00, 1'b0, 2);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder_rr_arbiter
